// File: rtl/life_pkg.sv
// life_pkg: shared definitions for the Game-of-Life engine.
//   state_t    - engine FSM states (IDLE, EVOLVE, COMMIT)
//   NBR_W      - width of a live-neighbour count (0..8)
//   nbr_bit()  - zero-extends one neighbour bit to NBR_W for summing
//   life_rule()- Conway birth/survival rule for one cell
package life_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVOLVE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NBR_W = 4;

  function automatic logic [NBR_W-1:0] nbr_bit(input logic b);
    return {{(NBR_W-1){1'b0}}, b};
  endfunction

  function automatic logic life_rule(input logic alive, input logic [NBR_W-1:0] n);
    return (n == NBR_W'(3)) || ((n == NBR_W'(2)) && alive);
  endfunction

endpackage

// File: rtl/life_row.sv
// life_row: combinational next-state of one grid row.
//   above     in  COLS  row above (already zeroed by caller at a dead edge)
//   curr      in  COLS  row being evolved
//   below     in  COLS  row below (already zeroed by caller at a dead edge)
//   wrap_mode in  1     1 = columns wrap around, 0 = off-grid columns are dead
//   next_row  out COLS  next generation of curr
module life_row #(
  parameter int COLS = 8
) (
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] curr,
  input  logic [COLS-1:0] below,
  input  logic            wrap_mode,
  output logic [COLS-1:0] next_row
);
  import life_pkg::*;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_cell
    localparam int L = (gi == 0) ? COLS - 1 : gi - 1;
    localparam int R = (gi == COLS - 1) ? 0 : gi + 1;

    // Edge columns only see their wrapped neighbour in toroidal mode.
    logic lv;
    logic rv;
    logic [NBR_W-1:0] n;

    assign lv = (gi != 0) || wrap_mode;
    assign rv = (gi != COLS - 1) || wrap_mode;

    assign n = nbr_bit(above[L] & lv) + nbr_bit(above[gi]) + nbr_bit(above[R] & rv)
             + nbr_bit(curr[L]  & lv)                      + nbr_bit(curr[R]  & rv)
             + nbr_bit(below[L] & lv) + nbr_bit(below[gi]) + nbr_bit(below[R] & rv);

    assign next_row[gi] = life_rule(curr[gi], n);
  end

endmodule

// File: rtl/life_engine.sv
// life_engine: row-serial Game-of-Life engine.
// One generation takes ROWS EVOLVE cycles (one row per cycle into a shadow
// buffer) followed by a COMMIT cycle that swaps the buffer into the grid.
//   clk, reset             clock and async active-high reset
//   load_valid/load_grid   load a new grid (IDLE only); load_ready high in IDLE
//   step / run             single generation / free-running evolution
//   wrap_mode              0 dead boundary, 1 toroidal (latched at start)
//   grid_out, gen_count    committed grid and generations since last load
//   gen_done               one-cycle pulse together with each new grid_out
//   busy, stable, extinct  status flags
module life_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [ROWS*COLS-1:0] load_grid,
  output logic                 load_ready,
  input  logic                 step,
  input  logic                 run,
  input  logic                 wrap_mode,
  output logic [ROWS*COLS-1:0] grid_out,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 gen_done,
  output logic                 busy,
  output logic                 stable,
  output logic                 extinct
);
  import life_pkg::*;

  localparam int ROW_W = $clog2(ROWS);
  localparam int N     = ROWS * COLS;

  state_t               state_reg, state_next;
  logic [ROW_W-1:0]     row_idx_reg;
  logic [N-1:0]         grid_reg;
  logic [COLS-1:0]      next_rows_reg [ROWS];
  logic [GEN_W-1:0]     gen_count_reg;
  logic                 gen_done_reg;
  logic                 stable_reg;
  logic                 extinct_reg;
  logic                 wrap_reg;

  logic [N-1:0]         next_flat;
  logic [COLS-1:0]      grid_rows [ROWS];
  logic                 start;
  logic                 last_row;
  logic [ROW_W-1:0]     up_idx, dn_idx;
  logic                 up_ok, dn_ok;
  logic [COLS-1:0]      above_row, curr_row, below_row, row_next;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
    assign grid_rows[gi]               = grid_reg[gi*COLS +: COLS];
    assign next_flat[gi*COLS +: COLS]  = next_rows_reg[gi];
  end

  // Load has priority over any evolution request.
  assign start    = !load_valid && (step || (run && !stable_reg && !extinct_reg));
  assign last_row = (row_idx_reg == ROW_W'(ROWS - 1));

  // Neighbouring row indices; top/bottom rows wrap only in toroidal mode.
  always_comb begin
    up_idx = row_idx_reg - 1'b1;
    dn_idx = row_idx_reg + 1'b1;
    up_ok  = 1'b1;
    dn_ok  = 1'b1;
    if (row_idx_reg == '0) begin
      up_idx = ROW_W'(ROWS - 1);
      up_ok  = wrap_reg;
    end
    if (last_row) begin
      dn_idx = '0;
      dn_ok  = wrap_reg;
    end
  end

  assign above_row = up_ok ? grid_rows[up_idx] : '0;
  assign curr_row  = grid_rows[row_idx_reg];
  assign below_row = dn_ok ? grid_rows[dn_idx] : '0;

  life_row #(.COLS(COLS)) u_row (
    .above     (above_row),
    .curr      (curr_row),
    .below     (below_row),
    .wrap_mode (wrap_reg),
    .next_row  (row_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = EVOLVE;
      EVOLVE:  if (last_row) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_idx_reg   <= '0;
      grid_reg      <= '0;
      gen_count_reg <= '0;
      gen_done_reg  <= 1'b0;
      stable_reg    <= 1'b0;
      extinct_reg   <= 1'b1;
      wrap_reg      <= 1'b0;
      for (int i = 0; i < ROWS; i++) next_rows_reg[i] <= '0;
    end else begin
      gen_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_valid) begin
            grid_reg      <= load_grid;
            gen_count_reg <= '0;
            stable_reg    <= 1'b0;
            extinct_reg   <= (load_grid == '0);
          end else if (start) begin
            wrap_reg    <= wrap_mode;
            row_idx_reg <= '0;
          end
        end
        EVOLVE: begin
          next_rows_reg[row_idx_reg] <= row_next;
          if (!last_row) row_idx_reg <= row_idx_reg + 1'b1;
        end
        COMMIT: begin
          // gen_done is registered so it rises together with the new grid.
          grid_reg      <= next_flat;
          gen_count_reg <= gen_count_reg + 1'b1;
          stable_reg    <= (next_flat == grid_reg);
          extinct_reg   <= (next_flat == '0);
          gen_done_reg  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign load_ready = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign grid_out   = grid_reg;
  assign gen_count  = gen_count_reg;
  assign gen_done   = gen_done_reg;
  assign stable     = stable_reg;
  assign extinct    = extinct_reg;

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: stimulus pushes the expected committed
// state for each generation it requests; monitors pop on every gen_done.
module tb_life_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] CORN    = 64'h8100_0000_0000_0081;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;

  typedef struct {
    logic [63:0] grid;
    logic [15:0] gen;
    logic        stable;
    logic        extinct;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];

  int tests = 0;
  int fails = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, step, run, wrap_mode;
  logic [63:0] load_grid;
  logic        load_ready, gen_done, busy, stable, extinct;
  logic [63:0] grid_out;
  logic [15:0] gen_count;

  logic        load_valid2, run2;
  logic [63:0] load_grid2;
  logic        load_ready2, gen_done2, busy2, stable2, extinct2;
  logic [63:0] grid_out2;
  logic [1:0]  gen_count2;

  always #5 clk = ~clk;

  life_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(16)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_grid(load_grid), .load_ready(load_ready),
    .step(step), .run(run), .wrap_mode(wrap_mode),
    .grid_out(grid_out), .gen_count(gen_count), .gen_done(gen_done),
    .busy(busy), .stable(stable), .extinct(extinct)
  );

  life_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .load_valid(load_valid2), .load_grid(load_grid2), .load_ready(load_ready2),
    .step(1'b0), .run(run2), .wrap_mode(1'b0),
    .grid_out(grid_out2), .gen_count(gen_count2), .gen_done(gen_done2),
    .busy(busy2), .stable(stable2), .extinct(extinct2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grid"},       grid_out,   64'h0);
    check({tag, "_gen_count"},  64'(gen_count), 64'h0);
    check({tag, "_gen_done"},   64'(gen_done),  64'h0);
    check({tag, "_busy"},       64'(busy),      64'h0);
    check({tag, "_stable"},     64'(stable),    64'h0);
    check({tag, "_extinct"},    64'(extinct),   64'h1);
    check({tag, "_load_ready"}, 64'(load_ready), 64'h1);
  endtask

  task automatic do_load(input logic [63:0] g);
    @(negedge clk);
    load_valid = 1'b1;
    load_grid  = g;
    @(negedge clk);
    load_valid = 1'b0;
    check("load_grid",    grid_out, g);
    check("load_gen",     64'(gen_count), 64'h0);
    check("load_extinct", 64'(extinct), 64'(g == 64'h0));
  endtask

  // Issues one step and checks gen_done arrives exactly ROWS+1 edges after
  // the sampling edge. With noise set, load/wrap are disturbed mid-evolve.
  task automatic do_step(input bit noise);
    @(negedge clk);
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    for (int k = 1; k <= ROWS + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == ROWS + 1) check("latency_gen_done", 64'(gen_done), 64'h1);
      else if (gen_done) check("early_gen_done", 64'(gen_done), 64'h0);
      if (noise && k == 3) begin
        check("busy_mid", 64'(busy), 64'h1);
        check("load_ready_mid", 64'(load_ready), 64'h0);
        load_valid = 1'b1;
        load_grid  = 64'hFFFF_FFFF_FFFF_FFFF;
        wrap_mode  = ~wrap_mode;
      end
      if (noise && k == 4) load_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && gen_done) begin
      if (q.size() == 0) begin
        check("unexpected_gen_done", 64'h1, 64'h0);
      end else begin
        e = q.pop_front();
        check("sb_grid",    grid_out, e.grid);
        check("sb_gen",     64'(gen_count), 64'(e.gen));
        check("sb_stable",  64'(stable), 64'(e.stable));
        check("sb_extinct", 64'(extinct), 64'(e.extinct));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && gen_done2) begin
      if (q2.size() == 0) begin
        check("unexpected_gen_done2", 64'h1, 64'h0);
      end else begin
        e = q2.pop_front();
        check("sb2_grid",    grid_out2, e.grid);
        check("sb2_gen",     64'(gen_count2), 64'(e.gen));
        check("sb2_flags",   64'({stable2, extinct2}), 64'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    load_valid = 1'b0; load_grid = '0; step = 1'b0; run = 1'b0; wrap_mode = 1'b0;
    load_valid2 = 1'b0; load_grid2 = '0; run2 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Blinker oscillates with period 2.
    do_load(BLINK_H);
    q.push_back('{BLINK_V, 16'd1, 1'b0, 1'b0});
    do_step(1'b0);
    q.push_back('{BLINK_H, 16'd2, 1'b0, 1'b0});
    do_step(1'b0);

    // Corners die with a dead boundary; load and wrap changes while busy
    // must not disturb the generation in flight.
    do_load(CORN);
    wrap_mode = 1'b0;
    q.push_back('{64'h0, 16'd1, 1'b0, 1'b1});
    do_step(1'b1);

    // Corners form a wrapped 2x2 block in toroidal mode.
    do_load(CORN);
    @(negedge clk) wrap_mode = 1'b1;
    q.push_back('{CORN, 16'd1, 1'b1, 1'b0});
    do_step(1'b0);
    @(negedge clk) wrap_mode = 1'b0;

    // Block still life under run: one generation, then halted.
    do_load(BLOCK);
    q.push_back('{BLOCK, 16'd1, 1'b1, 1'b0});
    @(negedge clk) run = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (gen_done) begin n = 1; break; end
    end
    if (n == 0) check("run_timeout", 64'h0, 64'h1);
    repeat (30) @(negedge clk);
    check("run_halt_busy", 64'(busy), 64'h0);
    check("run_halt_gen",  64'(gen_count), 64'h1);
    run = 1'b0;

    // Load and step together: load wins, step dropped.
    @(negedge clk);
    load_valid = 1'b1; load_grid = BLINK_H; step = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; step = 1'b0;
    check("ls_grid", grid_out, BLINK_H);
    repeat (12) @(negedge clk);
    check("ls_busy", 64'(busy), 64'h0);
    check("ls_grid_after", grid_out, BLINK_H);
    check("ls_gen", 64'(gen_count), 64'h0);

    // Reset in the middle of EVOLVE aborts without committing.
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    check("pre_reset_busy", 64'(busy), 64'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("midreset");
    @(negedge clk) reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_reset_grid", grid_out, 64'h0);
    check("post_reset_gen", 64'(gen_count), 64'h0);

    // Narrow counter wraps: 1,2,3,0,1.
    @(negedge clk);
    load_valid2 = 1'b1; load_grid2 = BLINK_H;
    @(negedge clk);
    load_valid2 = 1'b0;
    q2.push_back('{BLINK_V, 16'd1, 1'b0, 1'b0});
    q2.push_back('{BLINK_H, 16'd2, 1'b0, 1'b0});
    q2.push_back('{BLINK_V, 16'd3, 1'b0, 1'b0});
    q2.push_back('{BLINK_H, 16'd0, 1'b0, 1'b0});
    q2.push_back('{BLINK_V, 16'd1, 1'b0, 1'b0});
    run2 = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (gen_done2) n++;
      if (n == 5) break;
    end
    run2 = 1'b0;
    check("run2_gens", 64'(n), 64'd5);
    repeat (20) @(negedge clk);
    check("run2_idle", 64'({busy2, load_ready2}), 64'h1);

    check("q_drained",  64'(q.size()),  64'h0);
    check("q2_drained", 64'(q2.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 Parameter ROWS, default 8, grid row count (>=3).
REQ-002 Parameter COLS, default 8, grid column count (>=3).
REQ-003 Parameter GEN_W, default 16, generation counter width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with the ports named as follows.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
REQ-005 The remaining ports SHALL be:
- load_valid  in  1  request to load a new grid.
- load_grid  in  ROWS*COLS  grid to load; cell (r,c) = bit r*COLS+c.
- load_ready  out  1  high only in IDLE.
- step  in  1  single-generation request (sampled in IDLE).
- run  in  1  level; free-running evolution while high.
- wrap_mode  in  1  0 = dead boundary, 1 = toroidal.
- grid_out  out  ROWS*COLS  current committed grid, same bit mapping.
- gen_count  out  GEN_W  generations committed since last load.
- gen_done  out  1  one-cycle pulse per committed generation.
- busy  out  1  high in EVOLVE/COMMIT.
- stable  out  1  last generation equalled its predecessor.
- extinct  out  1  committed grid all zero.

Function
REQ-006 Rule per cell: next = (n==3) | (n==2 & alive), where n = live neighbour count (0..8, 4-bit unsigned).
REQ-007 Dead boundary: off-grid neighbours count 0; toroidal: row/col indices taken modulo ROWS/COLS.
REQ-008 The FSM SHALL have states IDLE, EVOLVE, COMMIT.
REQ-009 IDLE with load_valid=1: grid <= load_grid, gen_count <= 0, stable <= 0, extinct <= (load_grid==0); stay IDLE.
REQ-010 IDLE with load_valid=0 and (step=1 or (run=1 and stable=0 and extinct=0)): latch wrap_mode, row index <= 0, go EVOLVE.
REQ-011 Simultaneous load_valid and step/run in IDLE: load wins; step is dropped.
REQ-012 EVOLVE: each cycle compute one row of next state from the committed grid into the next buffer; after row ROWS-1, go COMMIT.
REQ-013 COMMIT: grid <= next buffer; gen_count += 1 (wraps modulo 2^GEN_W); stable <= (next==grid); extinct <= (next==0); gen_done=1 for this cycle; go IDLE.
REQ-014 Latency: the updated grid_out, gen_count and gen_done pulse SHALL be visible ROWS+1 edges after the edge that samples step; throughput is one generation per ROWS+2 cycles under run.
REQ-015 load_valid, step and wrap_mode changes SHALL be ignored while busy; the committed grid is unchanged until COMMIT.
REQ-016 run SHALL halt (stay IDLE) while stable=1 or extinct=1; step still forces a generation.

Reset
REQ-017 Reset SHALL force IDLE, grid=0, next buffer=0, gen_count=0, gen_done=0, busy=0, stable=0, extinct=1, load_ready=1.
REQ-018 Reset mid-EVOLVE/COMMIT SHALL abort the generation with no partial commit.

Structure
REQ-019 Package life_pkg SHALL hold the state enum (IDLE, EVOLVE, COMMIT) and the rule function/neighbour-count width constant.
REQ-020 One sub-module life_row (combinational) SHALL compute COLS next cells from the row above, current and below plus wrap_mode.

Verification
REQ-021 8x8 blinker: load 0x0000_0000_1C00_0000, step -> after 9 edges grid_out=0x0000_0008_0808_0000, gen_count=1, gen_done pulse; step again -> original grid, gen_count=2.
REQ-022 Corners 0x8100_0000_0000_0081: wrap_mode=0 step -> grid 0, extinct=1; reload, wrap_mode=1 step -> grid unchanged, stable=1.
REQ-023 Block still life under run=1 -> exactly one gen_done, stable=1, then no further gen_done while run stays high.
REQ-024 load_valid during EVOLVE -> ignored, load_ready=0, generation completes normally; load_valid with step in IDLE -> grid loaded, no evolution.
REQ-025 Reset asserted mid-EVOLVE -> all outputs at reset values next cycle, grid_out=0, no gen_done.
REQ-026 GEN_W=2, run on blinker -> gen_count sequence 1,2,3,0,1.
